// File: rtl/store_ctrl_pkg.sv
// store_ctrl_pkg
// Shared definitions for the store controller: FSM state encoding, the
// datapath/bank geometry and a one-hot bank decoder.
package store_ctrl_pkg;

  localparam int DATA_W    = 8;
  localparam int NUM_BANKS = 4;
  localparam int ADDR_W    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    STROBE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Decode a bank address into a single-bit store strobe vector.
  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [ADDR_W-1:0] addr);
    logic [NUM_BANKS-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/store_ctrl_if.sv
// store_ctrl_if
// Bundles the button/switch inputs and the bank-facing outputs of the store
// controller.
//   btn_store   : raw push-button (asynchronous, bouncing)
//   sw_data     : byte to store
//   sw_addr     : destination bank
//   data        : registered byte to all banks
//   store       : one-hot store strobe, one bit per bank
//   busy        : controller is handling a press
//   store_count : completed stores, modulo 256
// master = stimulus side (switches/button), slave = the controller.
import store_ctrl_pkg::*;

interface store_ctrl_if;
  logic                 btn_store;
  logic [DATA_W-1:0]    sw_data;
  logic [ADDR_W-1:0]    sw_addr;
  logic [DATA_W-1:0]    data;
  logic [NUM_BANKS-1:0] store;
  logic                 busy;
  logic [7:0]           store_count;

  modport master (
    output btn_store, sw_data, sw_addr,
    input  data, store, busy, store_count
  );

  modport slave (
    input  btn_store, sw_data, sw_addr,
    output data, store, busy, store_count
  );
endinterface

// File: rtl/store_ctrl_btn_sync.sv
// btn_sync
// Two-flop synchronizer bringing the asynchronous push-button into the clk
// domain. Only the second flop is meant to be used by downstream logic.
//   clk   : clock
//   reset : synchronous active-high reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output (second flop)
module btn_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/store_ctrl.sv
// store_ctrl
// Debounces a store push-button and, once per physical press, captures the
// switch byte/address and pulses a one-hot store strobe to one of the banks.
// A press must be stable for DEBOUNCE_CYCLES synchronized cycles before the
// strobe, and the release must be stable for the same count before the next
// press is accepted.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : store_ctrl_if slave (btn_store, sw_data, sw_addr in;
//           data, store, busy, store_count out, all registered)
module store_ctrl
  import store_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  store_ctrl_if.slave  bus
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic btn_s;

  btn_sync u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.btn_store),
    .q     (btn_s)
  );

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [NUM_BANKS-1:0] store_q, store_d;
  logic                 busy_q, busy_d;
  logic [7:0]           count_q, count_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    addr_d  = addr_q;
    count_d = count_q;

    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS;
          cnt_d   = '0;
        end
      end

      PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          // Capture happens on the same edge that enters STROBE, so data is
          // already stable when the strobe is seen by the banks.
          state_d = STROBE;
          data_d  = bus.sw_data;
          addr_d  = bus.sw_addr;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STROBE: begin
        state_d = RELEASE;
        cnt_d   = '0;
        count_d = count_q + 8'd1;
      end

      RELEASE: begin
        // Any high sample restarts the release debounce.
        if (btn_s) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from next-state so they line up with the state
    // register instead of lagging it by a cycle.
    store_d = (state_d == STROBE) ? bank_onehot(addr_d) : '0;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      store_q <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign bus.data        = data_q;
  assign bus.store       = store_q;
  assign bus.busy        = busy_q;
  assign bus.store_count = count_q;

endmodule

// File: tb/tb_store_ctrl.sv
// tb_store_ctrl
// Directed bench for store_ctrl with DEBOUNCE_CYCLES=4. Edge k=0 is the first
// edge that samples btn_store=1; the strobe is expected right after edge 6.
module tb_store_ctrl;
  import store_ctrl_pkg::*;

  localparam int DB = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  store_ctrl_if bus();

  store_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.btn_store = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Hold the current button level for n edges, recording strobes seen.
  task automatic run_hold(input int n, output int strobes, output int first_k,
                          output logic [3:0] sval);
    strobes = 0;
    first_k = -1;
    sval    = 4'b0000;
    for (int k = 0; k < n; k++) begin
      tick();
      if (bus.store !== 4'b0000) begin
        strobes++;
        if (first_k < 0) begin
          first_k = k;
          sval    = bus.store;
        end
      end
    end
  endtask

  task automatic run_release(input int n, output int strobes);
    strobes = 0;
    bus.btn_store = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (bus.store !== 4'b0000) strobes++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.btn_store = 1'b1;
    bus.sw_data = 8'h77;
    bus.sw_addr = 2'd3;
    tick();
    tick();
    tick();
    n_checks++;
    if (bus.store !== 4'b0000) begin n_fail++; $display("FAIL reset_store: got %b want 0000", bus.store); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++;
    if (bus.data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus.data); end
    n_checks++;
    if (bus.store_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.store_count); end
    bus.btn_store = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_store;
    do_reset();
    bus.sw_data = 8'hA5;
    bus.sw_addr = 2'd2;
    bus.btn_store = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp_store = (k == 6) ? 4'b0100 : 4'b0000;
      n_checks++;
      if (bus.store !== exp_store) begin n_fail++; $display("FAIL clean_store k=%0d: got %b want %b", k, bus.store, exp_store); end
      n_checks++;
      if (bus.busy !== (k >= 2)) begin n_fail++; $display("FAIL clean_busy k=%0d: got %b want %b", k, bus.busy, (k >= 2)); end
      n_checks++;
      if (bus.store_count !== ((k >= 7) ? 8'd1 : 8'd0)) begin
        n_fail++; $display("FAIL clean_count k=%0d: got %0d want %0d", k, bus.store_count, (k >= 7) ? 1 : 0);
      end
      if (k >= 6) begin
        n_checks++;
        if (bus.data !== 8'hA5) begin n_fail++; $display("FAIL clean_data k=%0d: got %h want a5", k, bus.data); end
      end
    end
    bus.btn_store = 1'b0;
    for (int r = 0; r < 6; r++) begin
      tick();
      n_checks++;
      if (bus.busy !== (r < 5)) begin n_fail++; $display("FAIL clean_release_busy r=%0d: got %b want %b", r, bus.busy, (r < 5)); end
      n_checks++;
      if (bus.store !== 4'b0000) begin n_fail++; $display("FAIL clean_release_store r=%0d: got %b want 0000", r, bus.store); end
    end
    n_checks++;
    if (bus.data !== 8'hA5) begin n_fail++; $display("FAIL clean_final_data: got %h want a5", bus.data); end
  endtask

  task automatic test_input_isolation();
    int s;
    do_reset();
    bus.sw_data = 8'h3C;
    bus.sw_addr = 2'd0;
    bus.btn_store = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 6) begin
        n_checks++;
        if (bus.store !== 4'b0001) begin n_fail++; $display("FAIL iso_store: got %b want 0001", bus.store); end
        bus.sw_data = 8'hFF;
        bus.sw_addr = 2'd3;
      end
      if (k >= 6) begin
        n_checks++;
        if (bus.data !== 8'h3C) begin n_fail++; $display("FAIL iso_data k=%0d: got %h want 3c", k, bus.data); end
      end
      if (k > 6) begin
        n_checks++;
        if (bus.store !== 4'b0000) begin n_fail++; $display("FAIL iso_store_after k=%0d: got %b want 0000", k, bus.store); end
      end
    end
    run_release(6, s);
    n_checks++;
    if (s !== 0) begin n_fail++; $display("FAIL iso_release_strobes: got %0d want 0", s); end
    n_checks++;
    if (bus.data !== 8'h3C) begin n_fail++; $display("FAIL iso_final_data: got %h want 3c", bus.data); end
    n_checks++;
    if (bus.store_count !== 8'd1) begin n_fail++; $display("FAIL iso_count: got %0d want 1", bus.store_count); end
  endtask

  task automatic test_bounce();
    int s, fk, s2, bounce_strobes;
    logic [3:0] sv;
    do_reset();
    bus.sw_data = 8'hC3;
    bus.sw_addr = 2'd1;
    bounce_strobes = 0;
    for (int i = 0; i < 10; i++) begin
      bus.btn_store = (i % 2 == 0);
      tick();
      if (bus.store !== 4'b0000) bounce_strobes++;
    end
    bus.btn_store = 1'b1;
    run_hold(10, s, fk, sv);
    n_checks++;
    if (bounce_strobes !== 0) begin n_fail++; $display("FAIL bounce_no_strobe: got %0d want 0", bounce_strobes); end
    n_checks++;
    if (s !== 1) begin n_fail++; $display("FAIL bounce_strobes: got %0d want 1", s); end
    n_checks++;
    if (fk !== 6) begin n_fail++; $display("FAIL bounce_latency: got %0d want 6", fk); end
    n_checks++;
    if (sv !== 4'b0010) begin n_fail++; $display("FAIL bounce_store_val: got %b want 0010", sv); end
    run_release(6, s2);
    n_checks++;
    if (bus.store_count !== 8'd1 || s2 !== 0) begin
      n_fail++; $display("FAIL bounce_count: got count %0d extra %0d want 1/0", bus.store_count, s2);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL bounce_busy_end: got %b want 0", bus.busy); end
  endtask

  task automatic test_held_release();
    int s, fk, rel_strobes;
    logic [3:0] sv;
    do_reset();
    bus.sw_data = 8'h81;
    bus.sw_addr = 2'd3;
    bus.btn_store = 1'b1;
    run_hold(50, s, fk, sv);
    n_checks++;
    if (s !== 1 || fk !== 6) begin n_fail++; $display("FAIL held_strobe: got %0d at k=%0d want 1 at 6", s, fk); end
    n_checks++;
    if (sv !== 4'b1000) begin n_fail++; $display("FAIL held_store_val: got %b want 1000", sv); end
    rel_strobes = 0;
    for (int j = 0; j < 6; j++) begin
      bus.btn_store = (j % 2 == 1);
      tick();
      if (bus.store !== 4'b0000) rel_strobes++;
    end
    bus.btn_store = 1'b0;
    for (int r = 0; r < 6; r++) begin
      tick();
      if (bus.store !== 4'b0000) rel_strobes++;
      if (r >= 4) begin
        n_checks++;
        if (bus.busy !== (r < 5)) begin n_fail++; $display("FAIL held_busy r=%0d: got %b want %b", r, bus.busy, (r < 5)); end
      end
    end
    n_checks++;
    if (rel_strobes !== 0) begin n_fail++; $display("FAIL held_release_strobes: got %0d want 0", rel_strobes); end
    n_checks++;
    if (bus.store_count !== 8'd1) begin n_fail++; $display("FAIL held_count: got %0d want 1", bus.store_count); end
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if (bus.store !== 4'b0000 || bus.busy !== 1'b0 || bus.data !== 8'h00 || bus.store_count !== 8'd0) begin
      n_fail++;
      $display("FAIL %s: got store=%b busy=%b data=%h count=%0d want 0000/0/00/0",
               tag, bus.store, bus.busy, bus.data, bus.store_count);
    end
  endtask

  task automatic test_reset_mid_press();
    int s, fk, s2;
    logic [3:0] sv;
    do_reset();
    bus.sw_data = 8'h5A;
    bus.sw_addr = 2'd1;
    bus.btn_store = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midpress_pre_busy: got %b want 1", bus.busy); end
    reset = 1'b1;
    tick();
    check_reset_values("midpress_reset");
    reset = 1'b0;
    run_hold(10, s, fk, sv);
    n_checks++;
    if (s !== 1 || fk !== 6 || sv !== 4'b0010) begin
      n_fail++; $display("FAIL midpress_restart: got %0d strobes k=%0d val=%b want 1 k=6 val=0010", s, fk, sv);
    end
    run_release(6, s2);
    n_checks++;
    if (bus.store_count !== 8'd1 || bus.data !== 8'h5A) begin
      n_fail++; $display("FAIL midpress_after: got count %0d data %h want 1/5a", bus.store_count, bus.data);
    end
  endtask

  task automatic test_reset_mid_strobe();
    int s, fk, s2;
    logic [3:0] sv;
    do_reset();
    bus.sw_data = 8'hE7;
    bus.sw_addr = 2'd2;
    bus.btn_store = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    n_checks++;
    if (bus.store !== 4'b0100) begin n_fail++; $display("FAIL midstrobe_pre_store: got %b want 0100", bus.store); end
    reset = 1'b1;
    tick();
    check_reset_values("midstrobe_reset");
    reset = 1'b0;
    run_hold(10, s, fk, sv);
    n_checks++;
    if (s !== 1 || fk !== 6 || sv !== 4'b0100) begin
      n_fail++; $display("FAIL midstrobe_restart: got %0d strobes k=%0d val=%b want 1 k=6 val=0100", s, fk, sv);
    end
    run_release(6, s2);
    n_checks++;
    if (bus.store_count !== 8'd1 || bus.data !== 8'hE7) begin
      n_fail++; $display("FAIL midstrobe_after: got count %0d data %h want 1/e7", bus.store_count, bus.data);
    end
  endtask

  task automatic test_wrap();
    int total, s, fk, s2;
    logic [3:0] sv;
    do_reset();
    total = 0;
    bus.sw_addr = 2'd3;
    for (int p = 0; p < 256; p++) begin
      bus.sw_data = 8'(p);
      bus.btn_store = 1'b1;
      run_hold(8, s, fk, sv);
      total += s;
      run_release(6, s2);
      total += s2;
      if (p == 254) begin
        n_checks++;
        if (bus.store_count !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d want 255", bus.store_count); end
      end
    end
    n_checks++;
    if (bus.store_count !== 8'd0) begin n_fail++; $display("FAIL wrap_count: got %0d want 0", bus.store_count); end
    n_checks++;
    if (total !== 256) begin n_fail++; $display("FAIL wrap_strobes: got %0d want 256", total); end
    n_checks++;
    if (bus.data !== 8'hFF || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL wrap_final: got data %h busy %b want ff/0", bus.data, bus.busy);
    end
  endtask

  initial begin
    bus.btn_store = 1'b0;
    bus.sw_data   = 8'h00;
    bus.sw_addr   = 2'd0;
    test_reset();
    test_clean_press();
    test_input_isolation();
    test_bounce();
    test_held_release();
    test_reset_mid_press();
    test_reset_mid_strobe();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_ctrl.md
STORE_CTRL -- requirements
Module: store_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized cycles required to accept a press or a release; legal range 2..65535.
REQ-002 clk  in  1  single clock; every register updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 btn_store  in  1  raw, asynchronous, bouncing store push-button.
REQ-005 sw_data  in  8  byte to be stored, from switches.
REQ-006 sw_addr  in  2  bank select among 4 downstream byte_memory instances.
REQ-007 data  out  8  registered byte driven to the data inputs of all banks.
REQ-008 store  out  4  one-hot store strobe, bit i drives the store input of bank i.
REQ-009 busy  out  1  high whenever the FSM is not in IDLE.
REQ-010 store_count  out  8  number of completed stores, modulo 256.

Function
REQ-011 btn_store SHALL pass through a 2-flop synchronizer; the FSM SHALL see only the second flop (btn_s).
REQ-012 FSM states SHALL be IDLE, PRESS, STROBE and RELEASE.
REQ-013 IDLE: when btn_s=1, go to PRESS and set cnt=0; otherwise stay.
REQ-014 PRESS: when btn_s=0, go to IDLE and clear cnt; when btn_s=1 and cnt=DEBOUNCE_CYCLES-1, go to STROBE; otherwise increment cnt.
REQ-015 On the PRESS->STROBE edge, sw_data SHALL be captured into data and sw_addr into an address register in the same edge.
REQ-016 STROBE SHALL last exactly 1 cycle, with store = one-hot(addr) and all other bits 0; then go to RELEASE and clear cnt.
REQ-017 store SHALL be 4'b0000 in every state other than STROBE; data SHALL hold its value outside the capture edge, so it is stable before, during and after the strobe.
REQ-018 RELEASE: each btn_s=0 cycle increments cnt; any btn_s=1 clears cnt; at cnt=DEBOUNCE_CYCLES-1 with btn_s=0, go to IDLE.
REQ-019 Latency: with btn_store held stable high, store SHALL be high in the cycle after rising edge number DEBOUNCE_CYCLES+2, counted from the first edge that samples btn_store=1.
REQ-020 One physical press, including any amount of bounce or hold time, SHALL produce exactly one strobe.
REQ-021 A bounce shorter than DEBOUNCE_CYCLES during PRESS SHALL produce no strobe.
REQ-022 store_count SHALL increment on the STROBE->RELEASE edge and wrap from 255 to 0.
REQ-023 sw_data and sw_addr changes outside the capture edge SHALL have no effect on the outputs.
REQ-024 The debounce counter SHALL be $clog2(DEBOUNCE_CYCLES) bits wide and SHALL never exceed DEBOUNCE_CYCLES-1.

Reset
REQ-025 reset=1 SHALL, at the next edge, force: state=IDLE, cnt=0, both sync flops=0, data=8'h00, address=0, store=4'b0000, busy=0, store_count=0.
REQ-026 reset SHALL take priority over every FSM transition, including a reset asserted during STROBE (the strobe is lost and store_count is not incremented).
REQ-027 After reset is released, a button still held SHALL be treated as a new press and SHALL require the full sync and debounce latency.

Structure
REQ-028 A shared package SHALL hold the state enum, DATA_W=8, NUM_BANKS=4 and ADDR_W=2.
REQ-029 The synchronizer SHALL be a separate sub-module, btn_sync (2 flops, reset to 0); the FSM, counter and registers SHALL remain in store_ctrl.
REQ-030 All outputs SHALL be driven directly from registers, with no combinational path from any input.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Clean press: sw_data=8'hA5, sw_addr=2, btn_store held high -> after the 6th edge store=4'b0100 for exactly 1 cycle, data=8'hA5, store_count=1, busy high from IDLE exit until the release debounce completes.
REQ-032 Bounce: btn_store toggles 1,0,1,0 per cycle for 10 cycles, then stays high -> no strobe during the toggling; exactly one strobe after the stable debounce.
REQ-033 Held and released bouncy: hold for 50 cycles, then release with 3 bounce cycles -> exactly one strobe; busy clears 4 stable-low cycles after the last bounce (plus the 2 sync cycles).
REQ-034 Wrap: 256 complete presses -> store_count back to 0, and store asserted exactly 256 times.
REQ-035 Reset mid-operation: reset asserted during PRESS and, separately, during STROBE -> all outputs at reset values on the next edge and store_count unchanged from 0; a button still held after reset -> one new strobe after the full latency.
REQ-036 Input isolation: sw_data changed from 8'h3C to 8'hFF in the cycle after the capture edge -> data remains 8'h3C.
